imuldiv_muldiv_arbiter: RTL and testbench

Two-port round-robin arbiter and response router that shares one iterative mul/div unit between two requesters, e.g. two pipeline lanes or a core plus an accelerator. It sits between the requesters and `imuldiv_IntMulDivIterative`. It keeps exactly one operation outstanding in the unit and records which requester owns it. The result is steered back to that owner only.

---
 rtl/imuldiv_muldiv_arbiter_pkg.sv | 16 +
 rtl/imuldiv_RoundRobinArb2.sv | 15 +
 rtl/imuldiv_muldiv_arbiter.sv | 98 +++++++++
 tb/tb_imuldiv_muldiv_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imuldiv_muldiv_arbiter_pkg.sv
// Shared definitions for the two-port mul/div arbiter: FSM states and the
// mul/div request function codes.
package imuldiv_muldiv_arbiter_pkg;

  typedef enum logic {
    IMULDIV_ARB_STATE_IDLE = 1'b0,
    IMULDIV_ARB_STATE_WAIT = 1'b1
  } arb_state_e;

  localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_MUL  = 3'd0;
  localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIV  = 3'd1;
  localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_DIVU = 3'd2;
  localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REM  = 3'd3;
  localparam logic [2:0] IMULDIV_MULDIVREQ_MSG_FUNC_REMU = 3'd4;

endpackage

// File: rtl/imuldiv_RoundRobinArb2.sv
// Two-input round-robin arbiter; the last-grant pointer lives in the parent.
module imuldiv_RoundRobinArb2 (
  input  logic [1:0] reqs,
  input  logic       last,
  output logic [1:0] grants
);

  always_comb begin
    grants = '0;
    // On a tie the requester that did not win last time goes first.
    if (reqs == 2'b11) grants = last ? 2'b01 : 2'b10;
    else               grants = reqs;
  end

endmodule

// File: rtl/imuldiv_muldiv_arbiter.sv
// Shares one iterative mul/div unit between two requesters, keeping a single
// op in flight and steering its result back to the requester that issued it.
module imuldiv_muldiv_arbiter
  import imuldiv_muldiv_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,

  input  logic [2:0]  req0_msg_fn,
  input  logic [31:0] req0_msg_a,
  input  logic [31:0] req0_msg_b,
  input  logic        req0_val,
  output logic        req0_rdy,
  output logic [63:0] resp0_msg_result,
  output logic        resp0_val,
  input  logic        resp0_rdy,

  input  logic [2:0]  req1_msg_fn,
  input  logic [31:0] req1_msg_a,
  input  logic [31:0] req1_msg_b,
  input  logic        req1_val,
  output logic        req1_rdy,
  output logic [63:0] resp1_msg_result,
  output logic        resp1_val,
  input  logic        resp1_rdy,

  output logic [2:0]  muldivreq_msg_fn,
  output logic [31:0] muldivreq_msg_a,
  output logic [31:0] muldivreq_msg_b,
  output logic        muldivreq_val,
  input  logic        muldivreq_rdy,
  input  logic [63:0] muldivresp_msg_result,
  input  logic        muldivresp_val,
  output logic        muldivresp_rdy
);

  arb_state_e state, state_next;
  logic       owner;
  logic       last;
  logic [1:0] grants;
  logic       grant_idx;
  logic       issue;

  imuldiv_RoundRobinArb2 rr_arb (
    .reqs   ({req1_val, req0_val}),
    .last   (last),
    .grants (grants)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IMULDIV_ARB_STATE_IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_next;
      if (issue) begin
        owner <= grant_idx;
        last  <= grant_idx;
      end
    end
  end

  always_comb begin
    state_next       = state;
    issue            = 1'b0;
    grant_idx        = grants[1];
    req0_rdy         = 1'b0;
    req1_rdy         = 1'b0;
    resp0_val        = 1'b0;
    resp1_val        = 1'b0;
    muldivreq_val    = 1'b0;
    muldivresp_rdy   = 1'b0;
    muldivreq_msg_fn = grant_idx ? req1_msg_fn : req0_msg_fn;
    muldivreq_msg_a  = grant_idx ? req1_msg_a  : req0_msg_a;
    muldivreq_msg_b  = grant_idx ? req1_msg_b  : req0_msg_b;
    resp0_msg_result = muldivresp_msg_result;
    resp1_msg_result = muldivresp_msg_result;

    case (state)
      IMULDIV_ARB_STATE_IDLE: begin
        muldivreq_val = |grants;
        req0_rdy      = grants[0] && muldivreq_rdy;
        req1_rdy      = grants[1] && muldivreq_rdy;
        issue         = muldivreq_val && muldivreq_rdy;
        if (issue) state_next = IMULDIV_ARB_STATE_WAIT;
      end
      IMULDIV_ARB_STATE_WAIT: begin
        resp0_val      = muldivresp_val && !owner;
        resp1_val      = muldivresp_val &&  owner;
        muldivresp_rdy = owner ? resp1_rdy : resp0_rdy;
        if (muldivresp_val && muldivresp_rdy) state_next = IMULDIV_ARB_STATE_IDLE;
      end
      default: state_next = IMULDIV_ARB_STATE_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imuldiv_muldiv_arbiter.sv
// Directed bench for the two-port mul/div arbiter with a behavioural mul/div
// unit, a transaction-level reference model and literal result expectations.
module tb_imuldiv_muldiv_arbiter;
  import imuldiv_muldiv_arbiter_pkg::*;

  localparam int LAT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  req0_msg_fn = '0, req1_msg_fn = '0;
  logic [31:0] req0_msg_a = '0, req0_msg_b = '0, req1_msg_a = '0, req1_msg_b = '0;
  logic        req0_val = 1'b0, req1_val = 1'b0;
  logic        req0_rdy, req1_rdy;
  logic [63:0] resp0_msg_result, resp1_msg_result;
  logic        resp0_val, resp1_val;
  logic        resp0_rdy = 1'b1, resp1_rdy = 1'b1;
  logic [2:0]  muldivreq_msg_fn;
  logic [31:0] muldivreq_msg_a, muldivreq_msg_b;
  logic        muldivreq_val;
  logic        muldivreq_rdy = 1'b1;
  logic [63:0] muldivresp_msg_result = '0;
  logic        muldivresp_val = 1'b0;
  logic        muldivresp_rdy;

  imuldiv_muldiv_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_msg_fn(req0_msg_fn), .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b),
    .req0_val(req0_val), .req0_rdy(req0_rdy),
    .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
    .req1_msg_fn(req1_msg_fn), .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b),
    .req1_val(req1_val), .req1_rdy(req1_rdy),
    .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
    .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
    .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
    .muldivreq_rdy(muldivreq_rdy), .muldivresp_msg_result(muldivresp_msg_result),
    .muldivresp_val(muldivresp_val), .muldivresp_rdy(muldivresp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] fn; logic [31:0] a; logic [31:0] b; } op_t;
  typedef struct { int port; logic [63:0] res; } rlog_t;

  op_t         rq0[$], rq1[$];
  logic [63:0] sb0[$], sb1[$];
  int          grant_log[$];
  rlog_t       resp_log[$];

  int n_vec = 0, n_err = 0;

  // Reference model: outstanding op (busy/owner) and the tie-break pointer.
  bit m_busy = 0, m_owner = 0, m_last = 1;
  bit fire_req0 = 0, fire_req1 = 0, unit_fire = 0, resp_fire = 0, rst_seen = 0;
  bit resp1_seen = 0, stray = 0;
  op_t cap;

  bit          u_busy = 0;
  int          u_cnt = 0;
  logic [63:0] u_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [63:0] unit_fn(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sbv;
    int     q, r;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sbv = longint'($signed(b));
    case (fn)
      IMULDIV_MULDIVREQ_MSG_FUNC_MUL: return 64'(sa * sbv);
      IMULDIV_MULDIVREQ_MSG_FUNC_DIV: begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {r, q};
      end
      IMULDIV_MULDIVREQ_MSG_FUNC_REM: begin
        q = $signed(a) / $signed(b); r = $signed(a) % $signed(b); return {q, r};
      end
      IMULDIV_MULDIVREQ_MSG_FUNC_DIVU: begin
        uq = a / b; ur = a % b; return {ur, uq};
      end
      default: begin
        uq = a / b; ur = a % b; return {uq, ur};
      end
    endcase
  endfunction

  // Compare process: checks every output each cycle at the falling edge.
  initial begin
    bit [1:0] v;
    bit has, g;
    logic [63:0] exp_res;
    forever begin
      @(negedge clk);
      v = {req1_val, req0_val};
      has = |v;
      g = (v == 2'b11) ? !m_last : v[1];
      if (resp1_val === 1'b1) resp1_seen = 1;
      if (!m_busy) begin
        check("idle_mreq_val", muldivreq_val, has);
        check("idle_req0_rdy", req0_rdy, has && !g && muldivreq_rdy);
        check("idle_req1_rdy", req1_rdy, has && g && muldivreq_rdy);
        check("idle_resp0_val", resp0_val, 0);
        check("idle_resp1_val", resp1_val, 0);
        check("idle_mresp_rdy", muldivresp_rdy, 0);
        if (has) begin
          check("mreq_fn", muldivreq_msg_fn, g ? req1_msg_fn : req0_msg_fn);
          check("mreq_a", muldivreq_msg_a, g ? req1_msg_a : req0_msg_a);
          check("mreq_b", muldivreq_msg_b, g ? req1_msg_b : req0_msg_b);
        end
      end else begin
        check("wait_mreq_val", muldivreq_val, 0);
        check("wait_req0_rdy", req0_rdy, 0);
        check("wait_req1_rdy", req1_rdy, 0);
        check("wait_resp0_val", resp0_val, muldivresp_val && !m_owner);
        check("wait_resp1_val", resp1_val, muldivresp_val && m_owner);
        check("wait_mresp_rdy", muldivresp_rdy, m_owner ? resp1_rdy : resp0_rdy);
        check("resp0_result", resp0_msg_result, muldivresp_msg_result);
        check("resp1_result", resp1_msg_result, muldivresp_msg_result);
      end

      fire_req0 = 0; fire_req1 = 0; unit_fire = 0; resp_fire = 0;
      rst_seen = reset;
      if (reset) begin
        m_busy = 0; m_owner = 0; m_last = 1;
        sb0.delete(); sb1.delete();
      end else if (!m_busy && has && muldivreq_rdy) begin
        m_busy = 1; m_owner = g; m_last = g;
        grant_log.push_back(int'(g));
        if (g) begin
          sb1.push_back(unit_fn(req1_msg_fn, req1_msg_a, req1_msg_b)); fire_req1 = 1;
        end else begin
          sb0.push_back(unit_fn(req0_msg_fn, req0_msg_a, req0_msg_b)); fire_req0 = 1;
        end
        cap = '{muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b};
        unit_fire = 1;
      end else if (m_busy && muldivresp_val && (m_owner ? resp1_rdy : resp0_rdy)) begin
        m_busy = 0; resp_fire = 1;
        if ((m_owner ? sb1.size() : sb0.size()) == 0) fail("resp_unexpected");
        else begin
          exp_res = m_owner ? sb1.pop_front() : sb0.pop_front();
          check(m_owner ? "sb_resp1" : "sb_resp0",
                m_owner ? resp1_msg_result : resp0_msg_result, exp_res);
          resp_log.push_back('{int'(m_owner), m_owner ? resp1_msg_result : resp0_msg_result});
        end
      end
    end
  end

  // Requesters and the behavioural mul/div unit, updated just after each edge.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (fire_req0) void'(rq0.pop_front());
      if (fire_req1) void'(rq1.pop_front());
      req0_val = rq0.size() > 0;
      req1_val = rq1.size() > 0;
      if (req0_val) {req0_msg_fn, req0_msg_a, req0_msg_b} = {rq0[0].fn, rq0[0].a, rq0[0].b};
      else          {req0_msg_fn, req0_msg_a, req0_msg_b} = '0;
      if (req1_val) {req1_msg_fn, req1_msg_a, req1_msg_b} = {rq1[0].fn, rq1[0].a, rq1[0].b};
      else          {req1_msg_fn, req1_msg_a, req1_msg_b} = '0;

      if (rst_seen) begin
        u_busy = 0; muldivresp_val = 0;
      end else begin
        if (resp_fire) begin u_busy = 0; muldivresp_val = 0; end
        if (unit_fire) begin
          u_busy = 1; u_cnt = LAT; u_res = unit_fn(cap.fn, cap.a, cap.b);
        end else if (u_busy && !muldivresp_val) begin
          u_cnt--;
          if (u_cnt == 0) begin muldivresp_val = 1; muldivresp_msg_result = u_res; end
        end
      end
      if (!u_busy) begin
        muldivresp_val = stray;
        muldivresp_msg_result = stray ? 64'hDEAD_BEEF_0BAD_F00D : '0;
      end
      muldivreq_rdy = !u_busy;
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      tick();
      done = rq0.size() == 0 && rq1.size() == 0 && !m_busy && !u_busy && !muldivresp_val;
    end
    check(name, done, 1);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    resp_log.delete();
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) tick();
    reset = 0;
    tick();
  endtask

  logic [63:0] fair_res[6];
  logic [63:0] fair_mask[6];

  initial begin
    fair_res  = '{64'd30, 64'd2, 64'hFFFF_FFFF_FFFF_FFF2, 64'd81, 64'd10, 64'h0000_0002_540B_E400};
    fair_mask = '{'1, 64'hFFFF_FFFF, '1, '1, 64'hFFFF_FFFF, '1};

    do_reset();
    check("rst_mreq_val", muldivreq_val, 0);
    check("rst_req0_rdy", req0_rdy, 0);
    check("rst_req1_rdy", req1_rdy, 0);
    check("rst_resp0_val", resp0_val, 0);
    check("rst_resp1_val", resp1_val, 0);
    check("rst_mresp_rdy", muldivresp_rdy, 0);

    // Single requester
    clear_logs(); resp1_seen = 0;
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd3, 32'd4});
    wait_done("single_done");
    check("single_count", resp_log.size(), 1);
    if (resp_log.size() > 0) begin
      check("single_port", resp_log[0].port, 0);
      check("single_res", resp_log[0].res, 64'd12);
    end
    check("single_no_resp1", resp1_seen, 0);

    // Tie straight after reset
    do_reset(); clear_logs();
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_DIV, 32'd100, 32'd7});
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_REM, 32'd100, 32'd7});
    wait_done("tie_done");
    check("tie_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      check("tie_grant0", grant_log[0], 0);
      check("tie_grant1", grant_log[1], 1);
      check("tie_port0", resp_log[0].port, 0);
      check("tie_div", resp_log[0].res[31:0], 32'd14);
      check("tie_port1", resp_log[1].port, 1);
      check("tie_rem", resp_log[1].res[31:0], 32'd2);
    end

    // Fairness with both requesters always valid
    clear_logs();
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd5, 32'd6});
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'hFFFF_FFFE, 32'd7});
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_DIVU, 32'd50, 32'd5});
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_REM, 32'd17, 32'd5});
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd9, 32'd9});
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd100000, 32'd100000});
    wait_done("fair_done");
    check("fair_count", resp_log.size(), 6);
    if (resp_log.size() == 6 && grant_log.size() == 6) begin
      for (int i = 0; i < 6; i++) begin
        check("fair_grant", grant_log[i], i % 2);
        check("fair_port", resp_log[i].port, i % 2);
        check("fair_res", resp_log[i].res & fair_mask[i], fair_res[i]);
      end
    end

    // Back-pressure on requester 1 while requester 0 waits
    clear_logs();
    resp1_rdy = 0;
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd11, 32'd11});
    for (int i = 0; i < 50 && resp1_val !== 1'b1; i++) tick();
    check("bp_resp1_rise", resp1_val, 1);
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd2, 32'd2});
    repeat (10) begin
      tick();
      check("bp_req0_rdy", req0_rdy, 0);
      check("bp_resp1_val", resp1_val, 1);
      check("bp_result", resp1_msg_result, 64'd121);
    end
    resp1_rdy = 1;
    wait_done("bp_done");
    check("bp_count", resp_log.size(), 2);
    if (resp_log.size() == 2) begin
      check("bp_port_first", resp_log[0].port, 1);
      check("bp_res_first", resp_log[0].res, 64'd121);
      check("bp_res_second", resp_log[1].res, 64'd4);
    end

    // Reset while an op is in flight
    clear_logs();
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd3, 32'd4});
    for (int i = 0; i < 20 && grant_log.size() == 0; i++) tick();
    check("rw_issued", grant_log.size(), 1);
    repeat (5) tick();
    reset = 1;
    tick();
    reset = 0;
    check("rw_resp0_val", resp0_val, 0);
    check("rw_mresp_rdy", muldivresp_rdy, 0);
    check("rw_mreq_val", muldivreq_val, 0);
    clear_logs();
    rq0.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd1, 32'd1});
    rq1.push_back('{IMULDIV_MULDIVREQ_MSG_FUNC_MUL, 32'd2, 32'd2});
    wait_done("rw_done");
    check("rw_count", resp_log.size(), 2);
    if (grant_log.size() > 0) check("rw_tie_grant", grant_log[0], 0);

    // Stray unit response while idle
    stray = 1;
    repeat (3) begin
      tick();
      check("stray_mresp_val", muldivresp_val, 1);
      check("stray_mresp_rdy", muldivresp_rdy, 0);
      check("stray_resp0_val", resp0_val, 0);
      check("stray_resp1_val", resp1_val, 0);
    end
    stray = 0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
